seq_mult_bcd_display: RTL and testbench



---
 rtl/seq_mult_bcd_display_pkg.sv | 50 +++++
 rtl/seq_mult_bcd_display_seg7_decoder.sv | 19 +
 rtl/seq_mult_bcd_display.sv | 157 +++++++++++++++
 tb/tb_seq_mult_bcd_display.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_bcd_display_pkg.sv
// Shared types and helpers for the sequential multiplier / BCD display block.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    CONV,
    DONE
  } state_t;

  localparam int unsigned DIGITS_DEFAULT = 2;
  localparam int unsigned BCD_W          = 4 * DIGITS_DEFAULT;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-decimal codes are blank.
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // 10^n, used to check that DIGITS can hold the largest product.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Largest product of two unsigned w-bit operands.
  function automatic longint unsigned max_product(input int unsigned w);
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    return m * m;
  endfunction

endpackage

// File: rtl/seq_mult_bcd_display_seg7_decoder.sv
// One BCD digit to seven-segment pattern {g,f,e,d,c,b,a}, selectable polarity.
module seg7_decoder
  import seq_mult_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Polarity applied on top of the active-low reference pattern.
  always_comb begin
    seg = seg7_encode(digit);
    if (!SEG_ACTIVE_LOW) begin
      seg = ~seg7_encode(digit);
    end
  end

endmodule

// File: rtl/seq_mult_bcd_display.sv
// Sequential shift-and-add multiplier with double-dabble BCD conversion and
// per-digit seven-segment output, driven by a start/done handshake.
module seq_mult_bcd_display
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH          = 3,
  parameter int unsigned DIGITS         = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    product,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned DW = BW + PW;
  localparam int unsigned CW = $clog2(PW);

  if (WIDTH < 2 || pow10(DIGITS) <= max_product(WIDTH)) begin : g_bad_params
    $fatal(1, "seq_mult_bcd_display: WIDTH must be >= 2 and 10^DIGITS must exceed (2^WIDTH-1)^2");
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_next;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [DW-1:0]   dab;
  logic [DW-1:0]   dab_adj;
  logic [PW-1:0]   product_r;
  logic [BW-1:0]   bcd_r;
  logic            done_r;
  logic            mul_last;
  logic            conv_last;

  assign mul_last  = (cnt == CW'(WIDTH - 1));
  assign conv_last = (cnt == CW'(PW - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed-length MUL and CONV phases, single DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = MUL;
      MUL:     if (mul_last)  state_nxt = CONV;
      CONV:    if (conv_last) state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Accumulator value after the current multiply step.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    dab_adj = dab;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (dab[PW + 4*i +: 4] >= 4'd5) begin
        dab_adj[PW + 4*i +: 4] = dab[PW + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Datapath: operand capture, multiply steps, conversion shifts, result registers.
  // The final multiply step loads the conversion register straight from
  // acc_next so CONV can start shifting on its first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      dab       <= '0;
      product_r <= '0;
      bcd_r     <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          if (mul_last) begin
            cnt <= '0;
            dab <= {{BW{1'b0}}, acc_next};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONV: begin
          dab <= dab_adj << 1;
          if (conv_last) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          product_r <= acc;
          bcd_r     <= dab[DW-1 -: BW];
          done_r    <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = done_r;
  assign product = product_r;
  assign bcd     = bcd_r;

  // Segment patterns follow the registered BCD, so they change only with it.
  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    seg7_decoder #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_seg7 (
      .digit(bcd_r[4*i +: 4]),
      .seg  (seg[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_seq_mult_bcd_display.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop on done.
module tb_seq_mult_bcd_display;

  typedef struct {
    int unsigned p;
    logic [11:0] bcd;
    logic [20:0] seg;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start3 = 1'b0;
  logic [2:0]  a3 = '0, b3 = '0;
  logic        busy3, done3;
  logic [5:0]  product3;
  logic [7:0]  bcd3;
  logic [13:0] seg3;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  product4;
  logic [11:0] bcd4;
  logic [20:0] seg4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t q3[$];
  exp_t q4[$];
  int unsigned last_p3 = 0;
  int unsigned hold3   = 0;

  seq_mult_bcd_display #(.WIDTH(3), .DIGITS(2), .SEG_ACTIVE_LOW(1'b1)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .product(product3), .bcd(bcd3), .seg(seg3)
  );

  seq_mult_bcd_display #(.WIDTH(4), .DIGITS(3), .SEG_ACTIVE_LOW(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4), .bcd(bcd4), .seg(seg4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Decimal digits by repeated division.
  function automatic logic [11:0] ref_bcd(input int unsigned p);
    logic [11:0] r;
    int unsigned v;
    v = p;
    for (int d = 0; d < 3; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [20:0] ref_seg(input logic [11:0] digits, input bit active_low);
    logic [6:0] tbl [10];
    logic [20:0] r;
    logic [3:0] dg;
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    for (int d = 0; d < 3; d++) begin
      dg = digits[4*d +: 4];
      r[7*d +: 7] = active_low ? tbl[dg] : ~tbl[dg];
    end
    return r;
  endfunction

  function automatic exp_t make_exp(input int unsigned x, input int unsigned y,
                                    input bit active_low, input int due);
    exp_t e;
    e.p   = x * y;
    e.bcd = ref_bcd(e.p);
    e.seg = ref_seg(e.bcd, active_low);
    e.due = due;
    return e;
  endfunction

  // Result monitors.
  always @(negedge clk) begin
    exp_t e;
    if (done3) begin
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done3: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = q3.pop_front();
        chk("latency3", cyc, e.due);
        chk("product3", 32'(product3), e.p);
        chk("bcd3", 32'(bcd3), 32'(e.bcd[7:0]));
        chk("seg3", 32'(seg3), 32'(e.seg[13:0]));
        chk("busy_at_done3", 32'(busy3), 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done4: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = q4.pop_front();
        chk("latency4", cyc, e.due);
        chk("product4", 32'(product4), e.p);
        chk("bcd4", 32'(bcd4), 32'(e.bcd));
        chk("seg4", 32'(seg4), 32'(e.seg));
      end
    end
  end

  task automatic issue3(input int unsigned x, input int unsigned y);
    int t;
    t = 0;
    @(negedge clk);
    while (busy3 && t < 80) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait3", 32'(busy3), 0);
    a3 = 3'(x); b3 = 3'(y); start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    q3.push_back(make_exp(x, y, 1'b1, cyc + 10));
    chk("busy_after_start3", 32'(busy3), 1);
    hold3   = last_p3;
    last_p3 = x * y;
  endtask

  // Disturb inputs while busy; results must not move and start must be ignored.
  task automatic interfere3(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy3) begin
        chk("hold3", 32'(product3), hold3);
        a3 = 3'($urandom_range(0, 7));
        b3 = 3'($urandom_range(0, 7));
        start3 = ($urandom_range(0, 2) == 0);
      end else begin
        start3 = 1'b0;
      end
    end
    start3 = 1'b0;
  endtask

  task automatic issue4(input int unsigned x, input int unsigned y);
    int t;
    t = 0;
    @(negedge clk);
    while (busy4 && t < 80) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait4", 32'(busy4), 0);
    a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    q4.push_back(make_exp(x, y, 1'b0, cyc + 13));
  endtask

  initial begin
    int n0;
    int t;
    logic [20:0] rst_seg_al;
    logic [20:0] rst_seg_ah;
    rst_seg_al = ref_seg(12'h000, 1'b1);
    rst_seg_ah = ref_seg(12'h000, 1'b0);

    // Reset and idle state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy3", 32'(busy3), 0);
    chk("rst_done3", 32'(done3), 0);
    chk("rst_product3", 32'(product3), 0);
    chk("rst_bcd3", 32'(bcd3), 0);
    chk("rst_seg3", 32'(seg3), 32'(rst_seg_al[13:0]));
    chk("rst_seg4", 32'(seg4), 32'(rst_seg_ah));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy3", 32'(busy3), 0);
    chk("idle_seg3", 32'(seg3), 32'(rst_seg_al[13:0]));

    // Directed corner operands.
    issue3(7, 7); interfere3(12);
    issue3(2, 5); interfere3(12);
    issue3(0, 7); interfere3(12);
    issue3(7, 0); interfere3(12);

    // Start held high: one acceptance every 11 edges, operands sampled only at acceptance.
    @(negedge clk);
    t = 0;
    while (busy3 && t < 80) begin
      @(negedge clk);
      t++;
    end
    a3 = 3'd3; b3 = 3'd3; start3 = 1'b1;
    @(posedge clk); #1;
    n0 = cyc;
    for (int k = 0; k < 3; k++) begin
      q3.push_back(make_exp(3, 3, 1'b1, n0 + 11*k + 10));
    end
    while (cyc < n0 + 32) begin
      @(negedge clk);
      if ((cyc - n0) % 11 == 2) begin a3 = 3'd7; b3 = 3'd6; end
      if ((cyc - n0) % 11 == 6) begin a3 = 3'd3; b3 = 3'd3; end
    end
    start3 = 1'b0;
    last_p3 = 9;

    // Reset in the middle of an operation aborts it without a done pulse.
    issue3(7, 5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q3.delete();
    @(posedge clk); #1;
    chk("abort_busy3", 32'(busy3), 0);
    chk("abort_done3", 32'(done3), 0);
    chk("abort_product3", 32'(product3), 0);
    chk("abort_bcd3", 32'(bcd3), 0);
    chk("abort_seg3", 32'(seg3), 32'(rst_seg_al[13:0]));
    @(negedge clk);
    rst = 1'b0;
    last_p3 = 0;
    issue3(1, 5); interfere3(12);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    t = 0;
    while (busy3 && t < 80) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b1; start3 = 1'b1; a3 = 3'd6; b3 = 3'd6;
    @(posedge clk); #1;
    chk("rst_vs_start_busy3", 32'(busy3), 0);
    @(negedge clk);
    rst = 1'b0; start3 = 1'b0;
    @(posedge clk); #1;
    chk("rst_vs_start_idle3", 32'(busy3), 0);
    last_p3 = 0;

    // Randomized operations with disturbances while busy.
    for (int i = 0; i < 25; i++) begin
      issue3($urandom_range(0, 7), $urandom_range(0, 7));
      interfere3($urandom_range(0, 14));
    end

    // Wider instance, active-high segments, three digits.
    issue4(15, 15);
    issue4(0, 0);
    issue4(9, 11);
    issue4(10, 10);
    for (int i = 0; i < 8; i++) begin
      issue4($urandom_range(0, 15), $urandom_range(0, 15));
    end

    // Let outstanding results drain.
    t = 0;
    while ((q3.size() + q4.size()) != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(q3.size() + q4.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
